// File: rtl/pit_pkg.sv
`default_nettype none
// ============================================================================
// Module : pit_pkg
// Brief  : Shared constants and types for the programmable interrupt timer:
//          PCSR bit positions, register offsets for the 8- and 16-bit bus
//          maps, the PCSR layout struct and the prescale-field default width.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package pit_pkg;

  // Default width of the prescale-select field.
  localparam int c_pre_width_dflt = 4;

  // PCSR bit positions.
  localparam int c_cnt_en  = 0;
  localparam int c_irq_en  = 1;
  localparam int c_flag    = 2;
  localparam int c_oneshot = 3;
  localparam int c_pre_lsb = 8;
  localparam int c_pre_msb = 11;

  // Register offsets, 16-bit map (one word per register).
  localparam logic [1:0] c_ofs16_pcsr  = 2'd0;
  localparam logic [1:0] c_ofs16_pmod  = 2'd1;
  localparam logic [1:0] c_ofs16_pcntr = 2'd2;

  // Register offsets, 8-bit map (one byte lane per address).
  localparam logic [2:0] c_ofs8_pcsr_lo  = 3'd0;
  localparam logic [2:0] c_ofs8_pcsr_hi  = 3'd1;
  localparam logic [2:0] c_ofs8_pmod_lo  = 3'd2;
  localparam logic [2:0] c_ofs8_pmod_hi  = 3'd3;
  localparam logic [2:0] c_ofs8_pcntr_lo = 3'd4;
  localparam logic [2:0] c_ofs8_pcntr_hi = 3'd5;

  // PCSR as seen on the bus. The high byte carries PRE zero-extended, so
  // any bits above the configured PRE width always read 0.
  typedef struct packed {
    logic [7:0] pre_byte;
    logic [3:0] rsvd;
    logic       oneshot;
    logic       flag;
    logic       irq_en;
    logic       cnt_en;
  } pcsr_t;

endpackage
`default_nettype wire

// File: rtl/pit_prescaler.sv
`default_nettype none
// ============================================================================
// Module : pit_prescaler
// Brief  : Divide-by-2^PRE prescaler. Emits tick_o on the cycle its count
//          reaches 2^PRE-1 while enabled. Cleared whenever disabled or when
//          the timer is restarted.
// Ports  : wb_clk_i     clock
//          async_rst_b  asynchronous reset, active-low
//          sync_reset   synchronous reset, active-high
//          en_i         count enable (CNT_EN)
//          restart_i    synchronous clear (PMOD write)
//          pre_i        prescale select
//          tick_o       divided tick, combinational from state
// Rev    : 1.0  initial release
// ============================================================================
module pit_prescaler #(
  parameter int PRE_WIDTH = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 async_rst_b,
  input  logic                 sync_reset,
  input  logic                 en_i,
  input  logic                 restart_i,
  input  logic [PRE_WIDTH-1:0] pre_i,
  output logic                 tick_o
);

  // Wide enough to hold the largest terminal value 2^(2^PRE_WIDTH-1)-1.
  localparam int c_cnt_w = (2 ** PRE_WIDTH) - 1;

  logic [c_cnt_w-1:0] pre_cnt_q;
  logic [c_cnt_w-1:0] pre_cnt_d;
  logic [c_cnt_w-1:0] w_term;

  // Terminal value 2^PRE-1: a mask of PRE low ones. A PRE change can leave
  // the count above the new terminal; it then wraps through zero naturally.
  assign w_term = ~({c_cnt_w{1'b1}} << pre_i);
  assign tick_o = en_i & (pre_cnt_q == w_term);

  always_comb begin
    pre_cnt_d = pre_cnt_q + c_cnt_w'(1);
    if (!en_i || restart_i || tick_o) begin
      pre_cnt_d = '0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge async_rst_b) begin
    if (!async_rst_b) begin
      pre_cnt_q <= '0;
    end else if (sync_reset) begin
      pre_cnt_q <= '0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pit_timer_core.sv
`default_nettype none
// ============================================================================
// Module : pit_timer_core
// Brief  : Register file and timing engine of the programmable interrupt
//          timer: PCSR, PMOD, 2^n prescaler and modulo counter PCNTR.
//          Optional one-shot mode is built when PIT_ONESHOT_EN is defined.
// Ports  : wb_clk_i     clock
//          async_rst_b  asynchronous reset, active-low
//          sync_reset   synchronous reset, active-high
//          bus_wr_data  write data from the bus stage
//          write_regs   byte strobes {PMOD hi, PMOD lo, PCSR hi, PCSR lo}
//          read_regs    {PCNTR, PMOD, PCSR}, 16 bits each
//          irq_source   FLAG & IRQ_EN
//          cnt_roll_o   one-cycle pulse the clock after a rollover
// Rev    : 1.0  initial release
// ============================================================================
module pit_timer_core
  import pit_pkg::*;
#(
  parameter int DWIDTH     = 16,
  parameter int COUNT_SIZE = 16,
  parameter int PRE_WIDTH  = c_pre_width_dflt
) (
  input  logic              wb_clk_i,
  input  logic              async_rst_b,
  input  logic              sync_reset,
  input  logic [DWIDTH-1:0] bus_wr_data,
  input  logic [3:0]        write_regs,
  output logic [47:0]       read_regs,
  output logic              irq_source,
  output logic              cnt_roll_o
);

  pcsr_t                 pcsr_q, pcsr_d;
  logic [COUNT_SIZE-1:0] pmod_q, pmod_d;
  logic [COUNT_SIZE-1:0] cnt_q, cnt_d;
  logic                  roll_q, roll_d;

  logic [7:0]            w_lane_lo;
  logic [7:0]            w_lane_hi;
  logic                  w_tick;
  logic                  w_restart;
  logic                  w_roll_raw;
  logic                  w_roll;
  logic [COUNT_SIZE-1:0] w_pmod_m1;
  logic [15:0]           w_pmod_ext;
  logic [15:0]           w_cnt_ext;
  logic [15:0]           w_pmod_wide;

  // Byte lane selection: an 8-bit bus presents every byte on bits [7:0].
  generate
    if (DWIDTH == 8) begin : g_lane8
      assign w_lane_lo = bus_wr_data[7:0];
      assign w_lane_hi = bus_wr_data[7:0];
    end else begin : g_lane16
      assign w_lane_lo = bus_wr_data[7:0];
      assign w_lane_hi = bus_wr_data[15:8];
    end
  endgenerate

  assign w_restart = write_regs[2] | write_regs[3];

  pit_prescaler #(
    .PRE_WIDTH (PRE_WIDTH)
  ) u_prescaler (
    .wb_clk_i    (wb_clk_i),
    .async_rst_b (async_rst_b),
    .sync_reset  (sync_reset),
    .en_i        (pcsr_q.cnt_en),
    .restart_i   (w_restart),
    .pre_i       (pcsr_q.pre_byte[PRE_WIDTH-1:0]),
    .tick_o      (w_tick)
  );

  // PMOD-1 wraps modulo 2^COUNT_SIZE, so PMOD=0 yields the full range.
  assign w_pmod_m1  = pmod_q - COUNT_SIZE'(1);
  assign w_roll_raw = w_tick & (cnt_q == w_pmod_m1);
  // A PMOD write in the rollover cycle cancels the rollover entirely.
  assign w_roll     = w_roll_raw & ~w_restart;

  always_comb begin
    w_pmod_ext = '0;
    w_cnt_ext  = '0;
    w_pmod_ext[COUNT_SIZE-1:0] = pmod_q;
    w_cnt_ext[COUNT_SIZE-1:0]  = cnt_q;
  end

  // Next-state for registers, counter and rollover pulse.
  always_comb begin
    pcsr_d      = pcsr_q;
    w_pmod_wide = w_pmod_ext;
    cnt_d       = cnt_q;
    roll_d      = w_roll;

    if (write_regs[0]) begin
      pcsr_d.cnt_en = w_lane_lo[c_cnt_en];
      pcsr_d.irq_en = w_lane_lo[c_irq_en];
`ifdef PIT_ONESHOT_EN
      pcsr_d.oneshot = w_lane_lo[c_oneshot];
`endif
      if (w_lane_lo[c_flag]) begin
        pcsr_d.flag = 1'b0;
      end
    end
    if (write_regs[1]) begin
      pcsr_d.pre_byte = 8'(w_lane_hi[PRE_WIDTH-1:0]);
    end

    // Hardware events follow software writes so they take priority.
    if (w_roll) begin
      pcsr_d.flag = 1'b1;
`ifdef PIT_ONESHOT_EN
      if (pcsr_q.oneshot) begin
        pcsr_d.cnt_en = 1'b0;
      end
`endif
    end

    if (write_regs[2]) begin
      w_pmod_wide[7:0] = w_lane_lo;
    end
    if (write_regs[3]) begin
      w_pmod_wide[15:8] = w_lane_hi;
    end
    pmod_d = w_pmod_wide[COUNT_SIZE-1:0];

    // Counter follows the current (registered) enable, so a write clearing
    // CNT_EN still lets a same-cycle rollover complete.
    if (!pcsr_q.cnt_en || w_restart || w_roll_raw) begin
      cnt_d = '0;
    end else if (w_tick) begin
      cnt_d = cnt_q + COUNT_SIZE'(1);
    end
  end

  always_ff @(posedge wb_clk_i or negedge async_rst_b) begin
    if (!async_rst_b) begin
      pcsr_q <= '0;
      pmod_q <= '0;
      cnt_q  <= '0;
      roll_q <= 1'b0;
    end else if (sync_reset) begin
      pcsr_q <= '0;
      pmod_q <= '0;
      cnt_q  <= '0;
      roll_q <= 1'b0;
    end else begin
      pcsr_q <= pcsr_d;
      pmod_q <= pmod_d;
      cnt_q  <= cnt_d;
      roll_q <= roll_d;
    end
  end

  assign read_regs  = {w_cnt_ext, w_pmod_ext, pcsr_q};
  assign irq_source = pcsr_q.flag & pcsr_q.irq_en;
  assign cnt_roll_o = roll_q;

endmodule
`default_nettype wire

// File: tb/tb_pit_timer_core.sv
`default_nettype none
// ============================================================================
// Module : tb_pit_timer_core
// Brief  : Directed self-checking bench for pit_timer_core. Three instances:
//          a = 16-bit bus / 16-bit counter, b = 8-bit bus / 16-bit counter,
//          c = 16-bit bus / 4-bit counter.
// Rev    : 1.0  initial release
// ============================================================================
module tb_pit_timer_core;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        srst_a = 1'b0, srst_b = 1'b0, srst_c = 1'b0;
  logic [3:0]  wr_a = '0, wr_b = '0, wr_c = '0;
  logic [15:0] dat_a = '0, dat_c = '0;
  logic [7:0]  dat_b = '0;
  logic [47:0] rd_a, rd_b, rd_c;
  logic        irq_a, irq_b, irq_c;
  logic        roll_a, roll_b, roll_c;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pit_timer_core #(.DWIDTH(16), .COUNT_SIZE(16)) u_dut_a (
    .wb_clk_i(clk), .async_rst_b(rst_b), .sync_reset(srst_a),
    .bus_wr_data(dat_a), .write_regs(wr_a), .read_regs(rd_a),
    .irq_source(irq_a), .cnt_roll_o(roll_a));

  pit_timer_core #(.DWIDTH(8), .COUNT_SIZE(16)) u_dut_b (
    .wb_clk_i(clk), .async_rst_b(rst_b), .sync_reset(srst_b),
    .bus_wr_data(dat_b), .write_regs(wr_b), .read_regs(rd_b),
    .irq_source(irq_b), .cnt_roll_o(roll_b));

  pit_timer_core #(.DWIDTH(16), .COUNT_SIZE(4)) u_dut_c (
    .wb_clk_i(clk), .async_rst_b(rst_b), .sync_reset(srst_c),
    .bus_wr_data(dat_c), .write_regs(wr_c), .read_regs(rd_c),
    .irq_source(irq_c), .cnt_roll_o(roll_c));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wra(input logic [3:0] s, input logic [15:0] d);
    wr_a = s; dat_a = d; step(); wr_a = '0;
  endtask

  task automatic wrb(input logic [3:0] s, input logic [7:0] d);
    wr_b = s; dat_b = d; step(); wr_b = '0;
  endtask

  task automatic wrc(input logic [3:0] s, input logic [15:0] d);
    wr_c = s; dat_c = d; step(); wr_c = '0;
  endtask

  task automatic test_reset();
    rst_b = 1'b0;
    step(); step();
    n_cmp++; if (rd_a !== 48'h0) begin n_err++; $display("FAIL reset_rd_a got %h want 0", rd_a); end
    n_cmp++; if (rd_b !== 48'h0) begin n_err++; $display("FAIL reset_rd_b got %h want 0", rd_b); end
    n_cmp++; if (rd_c !== 48'h0) begin n_err++; $display("FAIL reset_rd_c got %h want 0", rd_c); end
    n_cmp++; if ({irq_a, roll_a, irq_c, roll_c} !== 4'b0) begin n_err++; $display("FAIL reset_outs got %b want 0000", {irq_a, roll_a, irq_c, roll_c}); end
    rst_b = 1'b1;
    step();
    n_cmp++; if (rd_a !== 48'h0) begin n_err++; $display("FAIL post_reset_rd_a got %h want 0", rd_a); end
  endtask

  task automatic test_periodic();
    wra(4'b1100, 16'h0004);
    wra(4'b0011, 16'h0003);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (rd_a[47:32] !== 16'(i) || roll_a !== 1'b0 || rd_a[2] !== 1'b0) begin
        n_err++; $display("FAIL per_count[%0d] got cnt=%h roll=%b flag=%b want cnt=%h roll=0 flag=0", i, rd_a[47:32], roll_a, rd_a[2], 16'(i));
      end
      step();
    end
    n_cmp++; if ({rd_a[47:32], roll_a, rd_a[2], irq_a} !== {16'h0, 3'b111}) begin
      n_err++; $display("FAIL per_roll1 got cnt=%h roll=%b flag=%b irq=%b want 0,1,1,1", rd_a[47:32], roll_a, rd_a[2], irq_a);
    end
    for (int j = 1; j < 4; j++) begin
      step();
      n_cmp++; if (rd_a[47:32] !== 16'(j) || roll_a !== 1'b0) begin
        n_err++; $display("FAIL per_count2[%0d] got cnt=%h roll=%b want cnt=%h roll=0", j, rd_a[47:32], roll_a, 16'(j));
      end
    end
    step();
    n_cmp++; if (roll_a !== 1'b1 || rd_a[47:32] !== 16'h0) begin
      n_err++; $display("FAIL per_roll2 got roll=%b cnt=%h want 1,0", roll_a, rd_a[47:32]);
    end
    wra(4'b0001, 16'h0000);
    step(); step();
    n_cmp++; if (rd_a[47:32] !== 16'h0 || rd_a[15:0] !== 16'h0004 || irq_a !== 1'b0) begin
      n_err++; $display("FAIL disable_hold got cnt=%h pcsr=%h irq=%b want 0,0004,0", rd_a[47:32], rd_a[15:0], irq_a);
    end
    wra(4'b0001, 16'h0004);
    n_cmp++; if (rd_a[15:0] !== 16'h0000) begin n_err++; $display("FAIL flag_w1c got pcsr=%h want 0000", rd_a[15:0]); end
  endtask

  task automatic test_prescale_flag();
    int k;
    wra(4'b1100, 16'h0003);
    wra(4'b0011, 16'h0203);
    repeat (10) step();
    n_cmp++; if (rd_a[47:32] !== 16'h2 || rd_a[2] !== 1'b0) begin
      n_err++; $display("FAIL pre_mid got cnt=%h flag=%b want 2,0", rd_a[47:32], rd_a[2]);
    end
    step();
    wra(4'b0011, 16'h0207);
    n_cmp++; if (rd_a[2] !== 1'b1 || roll_a !== 1'b1 || rd_a[47:32] !== 16'h0) begin
      n_err++; $display("FAIL set_wins got flag=%b roll=%b cnt=%h want 1,1,0", rd_a[2], roll_a, rd_a[47:32]);
    end
    wra(4'b0011, 16'h0207);
    n_cmp++; if (rd_a[2] !== 1'b0 || irq_a !== 1'b0) begin
      n_err++; $display("FAIL flag_clear got flag=%b irq=%b want 0,0", rd_a[2], irq_a);
    end
    k = 0;
    while (roll_a !== 1'b1 && k < 30) begin step(); k++; end
    n_cmp++; if (k !== 11) begin n_err++; $display("FAIL pre_period got %0d want 11", k); end
    wra(4'b0011, 16'h0004);
    n_cmp++; if (rd_a[15:0] !== 16'h0000) begin n_err++; $display("FAIL pre_off got pcsr=%h want 0000", rd_a[15:0]); end
  endtask

  task automatic test_coincident();
    wra(4'b1100, 16'h0002);
    wra(4'b0011, 16'h0001);
    step();
    n_cmp++; if (rd_a[47:32] !== 16'h1) begin n_err++; $display("FAIL coin_pre got cnt=%h want 1", rd_a[47:32]); end
    wra(4'b0100, 16'h0002);
    n_cmp++; if (rd_a[2] !== 1'b0 || roll_a !== 1'b0 || rd_a[47:32] !== 16'h0) begin
      n_err++; $display("FAIL pmod_wins got flag=%b roll=%b cnt=%h want 0,0,0", rd_a[2], roll_a, rd_a[47:32]);
    end
    step(); step();
    n_cmp++; if (rd_a[2] !== 1'b1 || roll_a !== 1'b1) begin
      n_err++; $display("FAIL coin_next_roll got flag=%b roll=%b want 1,1", rd_a[2], roll_a);
    end
    step();
    wra(4'b0001, 16'h0004);
    n_cmp++; if (rd_a[15:0] !== 16'h0004 || roll_a !== 1'b1 || rd_a[47:32] !== 16'h0) begin
      n_err++; $display("FAIL en_clear_roll got pcsr=%h roll=%b cnt=%h want 0004,1,0", rd_a[15:0], roll_a, rd_a[47:32]);
    end
    step();
    n_cmp++; if (roll_a !== 1'b0 || rd_a[47:32] !== 16'h0) begin
      n_err++; $display("FAIL en_clear_hold got roll=%b cnt=%h want 0,0", roll_a, rd_a[47:32]);
    end
    wra(4'b0001, 16'h0004);
  endtask

  task automatic test_dwidth8();
    wrb(4'b0001, 8'h01);
    step(); step();
    n_cmp++; if (rd_b[47:32] !== 16'h2) begin n_err++; $display("FAIL b_count got %h want 2", rd_b[47:32]); end
    wrb(4'b0100, 8'h34);
    n_cmp++; if (rd_b[31:16] !== 16'h0034 || rd_b[47:32] !== 16'h0) begin
      n_err++; $display("FAIL b_pmod_lo got pmod=%h cnt=%h want 0034,0", rd_b[31:16], rd_b[47:32]);
    end
    step(); step();
    wrb(4'b1000, 8'h12);
    n_cmp++; if (rd_b[31:16] !== 16'h1234 || rd_b[47:32] !== 16'h0) begin
      n_err++; $display("FAIL b_pmod_hi got pmod=%h cnt=%h want 1234,0", rd_b[31:16], rd_b[47:32]);
    end
    wrb(4'b0010, 8'h03);
    n_cmp++; if (rd_b[15:0] !== 16'h0301) begin n_err++; $display("FAIL b_pcsr_hi got %h want 0301", rd_b[15:0]); end
    wrb(4'b0001, 8'h00);
  endtask

  task automatic test_fullrange();
    int k;
    logic [15:0] maxc;
    wrc(4'b0011, 16'h0001);
    k = 0; maxc = '0;
    while (roll_c !== 1'b1 && k < 40) begin
      if (rd_c[47:32] > maxc) maxc = rd_c[47:32];
      step(); k++;
    end
    n_cmp++; if (k !== 16 || maxc !== 16'h000F) begin
      n_err++; $display("FAIL c_period got k=%0d max=%h want 16,000f", k, maxc);
    end
    step(); k = 1;
    while (roll_c !== 1'b1 && k < 40) begin step(); k++; end
    n_cmp++; if (k !== 16 || rd_c[2] !== 1'b1) begin
      n_err++; $display("FAIL c_period2 got k=%0d flag=%b want 16,1", k, rd_c[2]);
    end
    wrc(4'b1100, 16'hFFFF);
    n_cmp++; if (rd_c[31:16] !== 16'h000F || rd_c[47:32] !== 16'h0) begin
      n_err++; $display("FAIL c_narrow got pmod=%h cnt=%h want 000f,0", rd_c[31:16], rd_c[47:32]);
    end
    wrc(4'b0011, 16'h0004);
  endtask

  task automatic test_async_reset();
    wra(4'b1100, 16'h0002);
    wra(4'b0011, 16'h0003);
    step(); step();
    n_cmp++; if (rd_a[2] !== 1'b1 || irq_a !== 1'b1 || roll_a !== 1'b1) begin
      n_err++; $display("FAIL ar_pre got flag=%b irq=%b roll=%b want 1,1,1", rd_a[2], irq_a, roll_a);
    end
    rst_b = 1'b0;
    #1;
    n_cmp++; if (rd_a !== 48'h0 || irq_a !== 1'b0 || roll_a !== 1'b0) begin
      n_err++; $display("FAIL async_clear got rd=%h irq=%b roll=%b want 0,0,0", rd_a, irq_a, roll_a);
    end
    #2;
    rst_b = 1'b1;
    step();
  endtask

  task automatic test_sync_reset();
    wra(4'b1100, 16'h0005);
    wra(4'b0011, 16'h0003);
    step(); step();
    n_cmp++; if (rd_a[47:32] !== 16'h2) begin n_err++; $display("FAIL sr_pre got cnt=%h want 2", rd_a[47:32]); end
    srst_a = 1'b1; wr_a = 4'b1111; dat_a = 16'h0F07;
    step();
    srst_a = 1'b0; wr_a = '0;
    n_cmp++; if (rd_a !== 48'h0) begin n_err++; $display("FAIL sync_clear got %h want 0", rd_a); end
    step();
    n_cmp++; if (rd_a !== 48'h0) begin n_err++; $display("FAIL sync_hold got %h want 0", rd_a); end
  endtask

  task automatic test_reserved();
    logic [15:0] exp;
`ifdef PIT_ONESHOT_EN
    exp = 16'h0F0B;
`else
    exp = 16'h0F03;
`endif
    wra(4'b0011, 16'hFFFF);
    n_cmp++; if (rd_a[15:0] !== exp) begin n_err++; $display("FAIL pcsr_rsvd got %h want %h", rd_a[15:0], exp); end
    wra(4'b0011, 16'h0004);
    step();
    n_cmp++; if (rd_a[15:0] !== 16'h0) begin n_err++; $display("FAIL pcsr_clr got %h want 0", rd_a[15:0]); end
  endtask

  task automatic test_oneshot();
`ifdef PIT_ONESHOT_EN
    int rolls;
    wra(4'b1100, 16'h0002);
    wra(4'b0011, 16'h000B);
    rolls = 0;
    repeat (10) begin step(); if (roll_a === 1'b1) rolls++; end
    n_cmp++; if (rolls !== 1) begin n_err++; $display("FAIL oneshot_rolls got %0d want 1", rolls); end
    n_cmp++; if (rd_a[15:0] !== 16'h000E || rd_a[47:32] !== 16'h0) begin
      n_err++; $display("FAIL oneshot_state got pcsr=%h cnt=%h want 000e,0", rd_a[15:0], rd_a[47:32]);
    end
    wra(4'b0011, 16'h0004);
`else
    wra(4'b0001, 16'h0008);
    n_cmp++; if (rd_a[3] !== 1'b0 || rd_a[15:0] !== 16'h0) begin
      n_err++; $display("FAIL oneshot_absent got pcsr=%h want 0000", rd_a[15:0]);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_prescale_flag();
    test_coincident();
    test_dwidth8();
    test_fullrange();
    test_async_reset();
    test_sync_reset();
    test_reserved();
    test_oneshot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
